// File: rtl/n_bit_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module      : n_bit_chunk_adder
//  Description : Multi-cycle adder/subtractor. Adds CHUNK bits of the latched
//                operands per clock with a rippling carry held in a register,
//                producing a WIDTH-bit result after WIDTH/CHUNK cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module n_bit_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int c_n     = WIDTH / CHUNK;
  localparam int c_cnt_w = (c_n > 1) ? $clog2(c_n) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [WIDTH-1:0]   r_acc;
  logic [CHUNK:0]     w_chunk_sum;
  logic [WIDTH-1:0]   w_result;
  logic               w_last;
  logic               w_load;

  assign w_last = (r_cnt == c_last);
  // A new operation may be accepted from IDLE or straight out of DONE.
  assign w_load = start && (r_state != ST_RUN);

  // Add the current chunk of both operands with the running carry and merge
  // it into the partial result, so the final edge can publish a full word.
  always_comb begin
    w_chunk_sum = {1'b0, r_a[r_cnt*CHUNK +: CHUNK]}
                + {1'b0, r_b[r_cnt*CHUNK +: CHUNK]}
                + (CHUNK+1)'(r_carry);
    w_result = r_acc;
    w_result[r_cnt*CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and status outputs; start is ignored while running.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? ST_RUN : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, chunk-serial accumulation and result publication.
  // Subtraction is a + ~b + ~cin, so cout=1 reads as "no borrow".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= cin ^ sub;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc   <= w_result;
      r_carry <= w_chunk_sum[CHUNK];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        sum  <= w_result;
        cout <= w_chunk_sum[CHUNK];
        // Carry-in XOR carry-out of the MSB, expressed via the sign bits:
        // like-signed operands producing an opposite-signed result.
        ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                (w_result[WIDTH-1] != r_a[WIDTH-1]);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_n_bit_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_n_bit_chunk_adder
//  Description : Directed and randomised checks of n_bit_chunk_adder with
//                WIDTH=8/CHUNK=2 and WIDTH=8/CHUNK=8 instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_n_bit_chunk_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0, sub = 1'b0;
  logic       busy0, done0, cout0, ovf0;
  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum0, sum1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  n_bit_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0)
  );

  n_bit_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  // Reference: integer arithmetic, signed range check for overflow.
  function automatic logic [9:0] ref_model(input logic [7:0] x, input logic [7:0] y,
                                           input logic c, input logic s);
    int  r, sa, sb, sr;
    logic co, ov;
    sa = int'($signed(x));
    sb = int'($signed(y));
    if (!s) begin
      r  = int'(x) + int'(y) + int'(c);
      co = (r > 255);
      sr = sa + sb + int'(c);
    end else begin
      r  = int'(x) - int'(y) - int'(c);
      co = (r >= 0);
      sr = sa - sb - int'(c);
    end
    ov = (sr > 127) || (sr < -128);
    return {r[7:0], co, ov};
  endfunction

  // Issue one operation on the selected instance; lat is the negedge index
  // (after the sampling edge) where done was seen, 0 on timeout.
  task automatic run_op(input int sel, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic ts, output int lat,
                        output int busycnt, output logic [9:0] res);
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts;
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    lat = 0;
    busycnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((sel == 0) ? busy0 : busy1) busycnt++;
      if ((sel == 0) ? done0 : done1) begin
        lat = i;
        break;
      end
    end
    res = (sel == 0) ? {sum0, cout0, ovf0} : {sum1, cout1, ovf1};
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy0, done0, sum0, cout0, ovf0} !== 12'h000) begin
      bad++;
      $display("FAIL reset_dut0 got=%h exp=000", {busy0, done0, sum0, cout0, ovf0});
    end
    total++;
    if ({busy1, done1, sum1, cout1, ovf1} !== 12'h000) begin
      bad++;
      $display("FAIL reset_dut1 got=%h exp=000", {busy1, done1, sum1, cout1, ovf1});
    end
    rst = 1'b0;
  endtask

  task automatic test_add_basic();
    int lat, bc;
    logic [9:0] res;
    run_op(0, 8'h55, 8'h33, 1'b0, 1'b0, lat, bc, res);
    total++;
    if (lat !== 5) begin bad++; $display("FAIL add_latency got=%0d exp=5", lat); end
    total++;
    if (bc !== 4) begin bad++; $display("FAIL add_busy_cycles got=%0d exp=4", bc); end
    total++;
    if (res !== {8'h88, 1'b1 == 1'b0, 1'b1}) begin
      bad++; $display("FAIL add_55_33 got=%h exp=%h", res, {8'h88, 1'b0, 1'b1});
    end
    @(negedge clk);
    total++;
    if ({done0, sum0, cout0, ovf0} !== {1'b0, 8'h88, 1'b0, 1'b1}) begin
      bad++; $display("FAIL add_hold got=%h exp=%h", {done0, sum0, cout0, ovf0}, {1'b0, 8'h88, 1'b0, 1'b1});
    end
  endtask

  task automatic test_add_carry();
    int lat, bc;
    logic [9:0] res;
    run_op(0, 8'hAC, 8'hB3, 1'b1, 1'b0, lat, bc, res);
    total++;
    if (lat !== 5 || res !== {8'h60, 1'b1, 1'b1}) begin
      bad++; $display("FAIL add_ac_b3 got=%h lat=%0d exp=%h", res, lat, {8'h60, 1'b1, 1'b1});
    end
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, lat, bc, res);
    total++;
    if (lat !== 5 || res !== {8'h00, 1'b1, 1'b0}) begin
      bad++; $display("FAIL add_ff_01 got=%h lat=%0d exp=%h", res, lat, {8'h00, 1'b1, 1'b0});
    end
  endtask

  task automatic test_sub();
    int lat, bc;
    logic [9:0] res;
    run_op(0, 8'h10, 8'h01, 1'b0, 1'b1, lat, bc, res);
    total++;
    if (lat !== 5 || res !== {8'h0F, 1'b1, 1'b0}) begin
      bad++; $display("FAIL sub_10_01 got=%h lat=%0d exp=%h", res, lat, {8'h0F, 1'b1, 1'b0});
    end
    run_op(0, 8'h00, 8'h01, 1'b1, 1'b1, lat, bc, res);
    total++;
    if (lat !== 5 || res !== {8'hFE, 1'b0, 1'b0}) begin
      bad++; $display("FAIL sub_00_01 got=%h lat=%0d exp=%h", res, lat, {8'hFE, 1'b0, 1'b0});
    end
  endtask

  // start held high: first op 0x12+0x34; operands switched mid-RUN to
  // 0x80+0x80, which the DONE-state restart picks up; later garbage ignored.
  task automatic test_back_to_back();
    int extra = 0;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start0 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 5) begin
        total++;
        if (!done0 || {sum0, cout0, ovf0} !== {8'h46, 1'b0, 1'b0}) begin
          bad++; $display("FAIL b2b_first got=%b/%h exp=1/%h", done0, {sum0, cout0, ovf0}, {8'h46, 1'b0, 1'b0});
        end
      end else if (c == 10) begin
        total++;
        if (!done0 || {sum0, cout0, ovf0} !== {8'h00, 1'b1, 1'b1}) begin
          bad++; $display("FAIL b2b_second got=%b/%h exp=1/%h", done0, {sum0, cout0, ovf0}, {8'h00, 1'b1, 1'b1});
        end
      end else if (done0) begin
        extra++;
      end
      if (c == 6) begin
        total++;
        if (busy0 !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy got=%b exp=1", busy0); end
      end
      if (c == 2) begin a = 8'h80; b = 8'h80; end
      if (c == 7) begin a = 8'hEE; b = 8'hEE; end
      if (c == 10) start0 = 1'b0;
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL b2b_done_width got=%0d exp=0", extra); end
  endtask

  task automatic test_async_reset();
    int lat, bc, seen = 0;
    logic [9:0] res;
    run_op(0, 8'h55, 8'h33, 1'b0, 1'b0, lat, bc, res);
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; sub = 1'b0; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy0, done0, sum0, cout0, ovf0} !== 12'h000) begin
      bad++; $display("FAIL async_reset got=%h exp=000", {busy0, done0, sum0, cout0, ovf0});
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done0 || busy0) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    run_op(0, 8'h01, 8'h01, 1'b0, 1'b0, lat, bc, res);
    total++;
    if (lat !== 5 || res !== {8'h02, 1'b0, 1'b0}) begin
      bad++; $display("FAIL after_reset got=%h lat=%0d exp=%h", res, lat, {8'h02, 1'b0, 1'b0});
    end
  endtask

  task automatic test_single_chunk();
    int lat, bc;
    logic [9:0] res;
    run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, lat, bc, res);
    total++;
    if (lat !== 2 || bc !== 1) begin
      bad++; $display("FAIL n1_timing got=lat%0d/busy%0d exp=lat2/busy1", lat, bc);
    end
    total++;
    if (res !== {8'h80, 1'b0, 1'b1}) begin
      bad++; $display("FAIL n1_7f_01 got=%h exp=%h", res, {8'h80, 1'b0, 1'b1});
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [9:0] res, exp;
    logic [7:0] ra, rb;
    logic rc, rs;
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      exp = ref_model(ra, rb, rc, rs);
      run_op(i % 2, ra, rb, rc, rs, lat, bc, res);
      total++;
      if (lat !== ((i % 2 == 0) ? 5 : 2) || res !== exp) begin
        bad++;
        $display("FAIL rand_%0d a=%h b=%h cin=%b sub=%b got=%h lat=%0d exp=%h",
                 i, ra, rb, rc, rs, res, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_add_carry();
    test_sub();
    test_back_to_back();
    test_async_reset();
    test_single_chunk();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
